mem_arbiter: RTL and testbench

Two-master physical bus arbiter placed directly downstream of the instruction-side and data-side virtual memory translators. It merges their physical request streams (page-table walks and final accesses) onto the single physical memory bus. It routes the slave acknowledge and read data back to the owning master. It accepts both single-cycle-pulse and level-held strobes.

---
 rtl/mem_arbiter.sv | 91 +++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master physical bus arbiter (I-side m0, D-side m1) onto one slave bus.
// Define ROUND_ROBIN_EN for round-robin on collisions; default is fixed m1 priority.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          rst,
    input  logic [AW-1:0] i_m0_addr,
    input  logic          i_m0_stb,
    input  logic [3:0]    i_m0_we,
    input  logic [DW-1:0] i_m0_dat_w,
    output logic          o_m0_ack,
    output logic [DW-1:0] o_m0_dat_r,
    input  logic [AW-1:0] i_m1_addr,
    input  logic          i_m1_stb,
    input  logic [3:0]    i_m1_we,
    input  logic [DW-1:0] i_m1_dat_w,
    output logic          o_m1_ack,
    output logic [DW-1:0] o_m1_dat_r,
    output logic [AW-1:0] o_s_addr,
    output logic          o_s_stb,
    output logic [3:0]    o_s_we,
    output logic [DW-1:0] o_s_dat_w,
    input  logic          i_s_ack,
    input  logic [DW-1:0] i_s_dat_r
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t state, state_n;
    logic pend0, pend1, last, pend0_n, pend1_n, last_n, stb_n;
    logic req0, req1, pick1, grant;
    logic [AW-1:0] addr_n;
    logic [3:0] we_n;
    logic [DW-1:0] dat_n;
    assign req0 = pend0 | i_m0_stb;
    assign req1 = pend1 | i_m1_stb;
`ifdef ROUND_ROBIN_EN
    assign pick1 = req1 & (~req0 | ~last);
`else
    assign pick1 = req1;
`endif
    assign grant = (state == IDLE) & (req0 | req1);
    assign o_m0_ack = i_s_ack & (state == OWN0);
    assign o_m1_ack = i_s_ack & (state == OWN1);
    assign o_m0_dat_r = i_s_dat_r;
    assign o_m1_dat_r = i_s_dat_r;
    // A strobe from the current owner is a protocol violation and is not queued.
    always_comb begin
        state_n = state;
        last_n  = last;
        stb_n   = 1'b0;
        addr_n  = o_s_addr;
        we_n    = o_s_we;
        dat_n   = o_s_dat_w;
        pend0_n = pend0 | (i_m0_stb & (state != OWN0));
        pend1_n = pend1 | (i_m1_stb & (state != OWN1));
        if (grant) begin
            state_n = pick1 ? OWN1 : OWN0;
            last_n  = pick1;
            stb_n   = 1'b1;
            addr_n  = pick1 ? i_m1_addr : i_m0_addr;
            we_n    = pick1 ? i_m1_we : i_m0_we;
            dat_n   = pick1 ? i_m1_dat_w : i_m0_dat_w;
            pend0_n = pick1 & pend0_n;
            pend1_n = ~pick1 & pend1_n;
        end else if (state != IDLE && i_s_ack) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge i_clk) begin
        if (rst) begin
            state     <= IDLE;
            pend0     <= 1'b0;
            pend1     <= 1'b0;
            last      <= 1'b0;
            o_s_stb   <= 1'b0;
            o_s_addr  <= '0;
            o_s_we    <= '0;
            o_s_dat_w <= '0;
        end else begin
            state     <= state_n;
            pend0     <= pend0_n;
            pend1     <= pend1_n;
            last      <= last_n;
            o_s_stb   <= stb_n;
            o_s_addr  <= addr_n;
            o_s_we    <= we_n;
            o_s_dat_w <= dat_n;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + randomized check of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
    logic i_clk = 1'b0;
    logic rst;
    logic [31:0] ma [2];
    logic [3:0]  mw [2];
    logic [31:0] md [2];
    logic        ms [2];
    logic        o_m0_ack, o_m1_ack, o_s_stb, s_ack;
    logic [31:0] o_m0_dat_r, o_m1_dat_r, o_s_addr, o_s_dat_w, s_dat;
    logic [3:0]  o_s_we;
    int checks = 0, failures = 0;
    int owner, mlast;
    bit mp [2];
    bit e_stb;
    bit eack [2];
    logic [31:0] e_addr, e_dw;
    logic [3:0]  e_we;
    bit act [2], lvl [2], sout;
    int scnt;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .i_clk(i_clk), .rst(rst),
        .i_m0_addr(ma[0]), .i_m0_stb(ms[0]), .i_m0_we(mw[0]), .i_m0_dat_w(md[0]),
        .o_m0_ack(o_m0_ack), .o_m0_dat_r(o_m0_dat_r),
        .i_m1_addr(ma[1]), .i_m1_stb(ms[1]), .i_m1_we(mw[1]), .i_m1_dat_w(md[1]),
        .o_m1_ack(o_m1_ack), .o_m1_dat_r(o_m1_dat_r),
        .o_s_addr(o_s_addr), .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_dat_w(o_s_dat_w),
        .i_s_ack(s_ack), .i_s_dat_r(s_dat)
    );

    task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    // One bus cycle of the reference: who owns the bus, who is waiting, what the slave sees.
    task automatic model_step();
        int prev, w;
        bit req [2];
        if (rst) begin
            owner = -1; mp[0] = 0; mp[1] = 0; mlast = 0;
            e_stb = 0; e_addr = 0; e_we = 0; e_dw = 0;
            return;
        end
        prev = owner;
        e_stb = 0;
        for (int i = 0; i < 2; i++) begin
            req[i] = mp[i] | ms[i];
            if (ms[i] && prev != i) mp[i] = 1;
        end
        if (prev == -1) begin
            if (req[0] || req[1]) begin
                w = req[1] ? 1 : 0;
`ifdef ROUND_ROBIN_EN
                if (req[0] && req[1]) w = (mlast == 1) ? 0 : 1;
`endif
                owner = w; mlast = w; mp[w] = 0; e_stb = 1;
                e_addr = ma[w]; e_we = mw[w]; e_dw = md[w];
            end
        end else if (s_ack) begin
            owner = -1;
        end
    endtask

    task automatic tick();
        #1;
        eack[0] = s_ack && owner == 0;
        eack[1] = s_ack && owner == 1;
        chk("m0_ack", o_m0_ack, eack[0]);
        chk("m1_ack", o_m1_ack, eack[1]);
        if (eack[0]) chk("m0_dat_r", o_m0_dat_r, s_dat);
        if (eack[1]) chk("m1_dat_r", o_m1_dat_r, s_dat);
        model_step();
        @(negedge i_clk);
        chk("s_stb", o_s_stb, e_stb);
        chk("s_addr", o_s_addr, e_addr);
        chk("s_we", o_s_we, e_we);
        chk("s_dat_w", o_s_dat_w, e_dw);
    endtask

    task automatic ack_now(input logic [31:0] d);
        s_ack = 1; s_dat = d;
        #1;
    endtask

    initial begin
        logic [31:0] walk [3];
        logic [31:0] ca, cb;
        walk[0] = 32'h8040_0004; walk[1] = 32'h8020_0008; walk[2] = 32'h0000_0ABC;
        rst = 1; s_ack = 0; s_dat = 0; sout = 0; scnt = 0;
        owner = -1; mlast = 0; mp[0] = 0; mp[1] = 0; e_stb = 0; e_addr = 0; e_we = 0; e_dw = 0;
        for (int i = 0; i < 2; i++) begin
            ma[i] = 0; mw[i] = 0; md[i] = 0; ms[i] = 0; act[i] = 0; lvl[i] = 0; eack[i] = 0;
        end
        @(negedge i_clk);
        tick(); tick();
        rst = 0;
        chk("reset_stb", o_s_stb, 0);
        chk("reset_addr", o_s_addr, 0);
        chk("reset_we", o_s_we, 0);
        chk("reset_dat_w", o_s_dat_w, 0);
        // single read
        ma[0] = 32'h8000_1000; mw[0] = 0; ms[0] = 1;
        tick(); ms[0] = 0;
        chk("rd_stb_c1", o_s_stb, 1);
        chk("rd_addr", o_s_addr, 32'h8000_1000);
        chk("rd_we", o_s_we, 0);
        tick();
        chk("rd_stb_c2", o_s_stb, 0);
        tick();
        ack_now(32'hDEAD_BEEF);
        chk("rd_m0_ack", o_m0_ack, 1);
        chk("rd_m0_dat", o_m0_dat_r, 32'hDEAD_BEEF);
        chk("rd_m1_ack", o_m1_ack, 0);
        tick(); s_ack = 0;
        // walk chain on m1, each request the cycle after the previous ack
        for (int k = 0; k < 3; k++) begin
            ma[1] = walk[k]; mw[1] = 0; ms[1] = 1;
            tick(); ms[1] = 0;
            chk("walk_stb", o_s_stb, 1);
            chk("walk_addr", o_s_addr, walk[k]);
            tick();
            ack_now(32'h100 + k);
            chk("walk_m1_ack", o_m1_ack, 1);
            chk("walk_m0_ack", o_m0_ack, 0);
            tick(); s_ack = 0;
        end
        // collision: last is 1 here, so round-robin picks m0 first
        ma[0] = 32'h0000_AAA0; ma[1] = 32'h0000_BBB0; ms[0] = 1; ms[1] = 1;
`ifdef ROUND_ROBIN_EN
        ca = 32'h0000_AAA0; cb = 32'h0000_BBB0;
`else
        ca = 32'h0000_BBB0; cb = 32'h0000_AAA0;
`endif
        tick(); ms[0] = 0; ms[1] = 0;
        chk("col_first", o_s_addr, ca);
        tick(); tick(); tick();
        ack_now(32'h55);
        tick(); s_ack = 0;
        chk("col_gap", o_s_stb, 0);
        tick();
        chk("col_second_stb", o_s_stb, 1);
        chk("col_second", o_s_addr, cb);
        ack_now(32'h66);
        tick(); s_ack = 0;
        // level strobe held until ack
        ma[1] = 32'h0000_0C00; mw[1] = 4'hF; md[1] = 32'h1234_5678; ms[1] = 1;
        tick();
        chk("lvl_stb", o_s_stb, 1);
        chk("lvl_we", o_s_we, 4'hF);
        chk("lvl_dat", o_s_dat_w, 32'h1234_5678);
        tick();
        ack_now(32'h77);
        chk("lvl_ack", o_m1_ack, 1);
        tick(); s_ack = 0; ms[1] = 0;
        chk("lvl_once_a", o_s_stb, 0);
        tick();
        chk("lvl_once_b", o_s_stb, 0);
        // reset mid-transaction with a late ack
        ma[0] = 32'h0000_0D00; mw[0] = 0; ms[0] = 1;
        tick(); ms[0] = 0;
        tick();
        rst = 1;
        tick(); rst = 0;
        ack_now(32'h88);
        chk("rst_late_ack", o_m0_ack, 0);
        tick(); s_ack = 0;
        chk("rst_stb", o_s_stb, 0);
        tick();
        chk("rst_no_pend", o_s_stb, 0);
        // stray ack in IDLE
        ack_now(32'h99);
        chk("stray_m0", o_m0_ack, 0);
        chk("stray_m1", o_m1_ack, 0);
        tick(); s_ack = 0;
        ma[0] = 32'h0000_0E00; ms[0] = 1;
        tick(); ms[0] = 0;
        chk("stray_next_stb", o_s_stb, 1);
        chk("stray_next_addr", o_s_addr, 32'h0000_0E00);
        ack_now(32'hAB);
        chk("stray_next_ack", o_m0_ack, 1);
        tick(); s_ack = 0;
        // randomized traffic: protocol-obeying masters, slave with 0..3 cycle latency
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(199) == 0);
            for (int m = 0; m < 2; m++) begin
                if (rst) begin
                    act[m] = 0; ms[m] = 0;
                end else begin
                    if (act[m] && eack[m]) act[m] = 0;
                    if (act[m]) ms[m] = lvl[m];
                    else if ($urandom_range(3) == 0) begin
                        act[m] = 1; lvl[m] = 1'($urandom_range(1));
                        ma[m] = $urandom; mw[m] = 4'($urandom_range(15)); md[m] = $urandom;
                        ms[m] = 1;
                    end else ms[m] = 0;
                end
            end
            s_ack = 0;
            if (e_stb) begin sout = 1; scnt = $urandom_range(3); end
            if (sout) begin
                if (scnt == 0) begin s_ack = 1; sout = 0; s_dat = $urandom; end
                else scnt--;
            end else if ($urandom_range(49) == 0) begin
                s_ack = 1; s_dat = $urandom;
            end
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
